genius_game_ctrl: RTL and testbench
===================================

Name: genius_game_ctrl

Overview:
- Game sequencer for the Genius (Simon) game.
- Grows a random color sequence and plays it back on four color LEDs.
- Accepts the player's replay from the remote-control decoder (valid strobe plus 2-bit color) and compares each press against the stored sequence.
- Reports score, win and lose to the top level and the display logic.

Parameters:
- MAX_LEN, 16, sequence length that wins the game (range 1..31).
- SHOW_TICKS, 4, ticks each color LED stays lit during playback (≥1).
- GAP_TICKS, 2, ticks of dark between playback steps (≥1).
- TIMEOUT_TICKS, 40, ticks allowed between player presses before loss (≥1).
- SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- tick  input  1  one-cycle timebase strobe; all durations are counted in ticks.
- start  input  1  level; sampled only in IDLE, WIN and LOSE.
- in_valid  input  1  decoder ready; may stay high for several cycles. Only a rising edge counts as a press.
- in_color  input  2  pressed color: 0 green, 1 red, 2 yellow, 3 blue. Sampled on the press cycle.
- led  output  4  one-hot color display; bit index equals color code.
- score  output  5  completed rounds in the current game.
- awaiting  output  1  high in WAIT_IN (player's turn).
- busy  output  1  high in any state except IDLE, WIN and LOSE.
- win  output  1  high in WIN.
- lose  output  1  high in LOSE.

Behaviour:
- Reset values: state=IDLE, led=0, score=0, awaiting=busy=win=lose=0, len=0, idx=0, counters=0, lfsr=SEED, in_valid_d=0. Sequence memory is not reset.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clock in every state. The color appended to the sequence is lfsr[1:0].
- Press detection: press = in_valid & ~in_valid_d. in_valid_d updates every cycle in every state.
  - A level held high across entry into WAIT_IN does not count as a press; the input must fall and rise again.
- Sequence memory: MAX_LEN x 2 bits; len is in 0..MAX_LEN.
- States and transitions:
  - IDLE: led=0. start=1 → APPEND, with len=0 and score=0.
  - APPEND (1 cycle): mem[len]<=lfsr[1:0]; len<=len+1; idx<=0; tick counter cleared → SHOW_ON.
  - SHOW_ON: led=onehot(mem[idx]). On the SHOW_TICKS-th tick → SHOW_OFF, counter cleared.
  - SHOW_OFF: led=0. On the GAP_TICKS-th tick:
    - idx==len-1 → WAIT_IN, idx=0, timeout counter cleared.
    - otherwise idx+1 → SHOW_ON.
  - WAIT_IN: led=0, awaiting=1.
    - press → latch in_color → CHECK.
    - Otherwise, on the TIMEOUT_TICKS-th tick → LOSE.
    - Press and tick in the same cycle: the press wins and the tick is not counted.
  - CHECK (1 cycle), comparing the latched color with mem[idx]:
    - Mismatch → LOSE.
    - Match with idx<len-1 → idx+1, timeout counter cleared → WAIT_IN.
    - Match with idx==len-1 → score+1; if len==MAX_LEN → WIN, else → APPEND.
  - WIN: led=4'b1111, win=1. start=1 → APPEND with len=0, score=0.
  - LOSE: led=0, lose=1, score held. start=1 → APPEND with len=0, score=0.
- start is ignored while busy.
- Presses outside WAIT_IN are ignored.
- Tick counters reset on every state entry. A tick on the entry cycle counts.
- Reset asserted mid-game returns to IDLE immediately (asynchronously). No press or start is acted on until rst has been high for one posedge.
- All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.

Test Plan:
1. Reset: rst=0 with random inputs → led=0, score=0, busy=awaiting=win=lose=0. After rst=1 with start=0, the block stays in IDLE.
2. Playback timing: tick every 4 clk, one-cycle start pulse → one LED one-hot for exactly 16 clk, then led=0 for 8 clk, then awaiting=1 with busy=1.
3. Correct play over 3 rounds: bench replays the colors observed on led, each in_valid high for 3 clk → score=1,2,3; round 4 shows 4 steps and steps 1–3 repeat the earlier colors.
4. Wrong color in round 2 at idx 0 → lose=1 two cycles after the press edge, led=0, score=1. Further presses cause no change. start → score=0, busy=1.
5. Timeout: no press in WAIT_IN → lose=1 on the cycle after the 40th tick. A press coincident with the 40th tick → CHECK instead, no loss.
6. MAX_LEN=2, full correct game → win=1, led=4'b1111, score=2. Also: in_valid held high from SHOW_OFF into WAIT_IN → no CHECK until in_valid falls and rises again.

Source files
------------

// File: rtl/genius_game_ctrl.sv
// rtl/genius_game_ctrl.sv - Genius (Simon) game sequencer: grows, plays back and checks a color sequence
module genius_game_ctrl #(
    parameter int         MAX_LEN       = 16,
    parameter int         SHOW_TICKS    = 4,
    parameter int         GAP_TICKS     = 2,
    parameter int         TIMEOUT_TICKS = 40,
    parameter logic [7:0] SEED          = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       in_valid,
    input  logic [1:0] in_color,
    output logic [3:0] led,
    output logic [4:0] score,
    output logic       awaiting,
    output logic       busy,
    output logic       win,
    output logic       lose
);
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MAX_SG  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int CNT_MAX = (TIMEOUT_TICKS > MAX_SG) ? TIMEOUT_TICKS : MAX_SG;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_TICKS - 1);
    localparam logic [4:0]    LEN_WIN   = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_APPEND, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_CHECK, S_WIN, S_LOSE
    } state_t;

    state_t        state;
    logic [4:0]    len;
    logic [4:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    lfsr;
    logic          in_valid_d;
    logic [1:0]    color_q;
    logic [1:0]    mem [MAX_LEN];

    logic       press;
    logic       last_step;
    logic [1:0] cur_color;

    assign press     = in_valid & ~in_valid_d;
    assign last_step = (idx == len - 5'd1);
    assign cur_color = mem[idx[AW-1:0]];

    // Every transition clears cnt, so each state counts ticks from its own entry cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
            cnt        <= '0;
            lfsr       <= SEED;
            in_valid_d <= 1'b0;
            color_q    <= '0;
            score      <= '0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            in_valid_d <= in_valid;
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start) begin
                        state <= S_APPEND;
                        len   <= '0;
                        score <= '0;
                        cnt   <= '0;
                    end
                end
                S_APPEND: begin
                    len   <= len + 5'd1;
                    idx   <= '0;
                    cnt   <= '0;
                    state <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (tick) begin
                        if (cnt == SHOW_LAST) begin
                            state <= S_SHOW_OFF;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_SHOW_OFF: begin
                    if (tick) begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (last_step) begin
                                idx   <= '0;
                                state <= S_WAIT_IN;
                            end else begin
                                idx   <= idx + 5'd1;
                                state <= S_SHOW_ON;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_WAIT_IN: begin
                    // A press beats a coincident tick; that tick is dropped.
                    if (press) begin
                        color_q <= in_color;
                        cnt     <= '0;
                        state   <= S_CHECK;
                    end else if (tick) begin
                        if (cnt == TO_LAST) begin
                            cnt   <= '0;
                            state <= S_LOSE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_CHECK: begin
                    cnt <= '0;
                    if (color_q != cur_color) begin
                        state <= S_LOSE;
                    end else if (!last_step) begin
                        idx   <= idx + 5'd1;
                        state <= S_WAIT_IN;
                    end else begin
                        score <= score + 5'd1;
                        state <= (len == LEN_WIN) ? S_WIN : S_APPEND;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_APPEND) mem[len[AW-1:0]] <= lfsr[1:0];
    end

    assign awaiting = (state == S_WAIT_IN);
    assign busy     = !(state inside {S_IDLE, S_WIN, S_LOSE});
    assign win      = (state == S_WIN);
    assign lose     = (state == S_LOSE);

    always_comb begin
        led = 4'b0000;
        if (state == S_SHOW_ON) led = 4'b0001 << cur_color;
        else if (state == S_WIN) led = 4'b1111;
    end
endmodule

// File: tb/tb_genius_game_ctrl.sv
// tb/tb_genius_game_ctrl.sv - directed self-checking bench for genius_game_ctrl
module tb_genius_game_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       tick_auto, tick_man;
    logic       start1, in_valid1, start2, in_valid2;
    logic [1:0] in_color1, in_color2;
    logic [3:0] led1, led2;
    logic [4:0] score1, score2;
    logic       awaiting1, busy1, win1, lose1;
    logic       awaiting2, busy2, win2, lose2;
    int         cyc = 0;
    int         total = 0, passed = 0, fails = 0;
    logic       sel = 1'b0;
    logic [7:0] m_lfsr;
    logic [1:0] seen [16];
    logic [1:0] hist [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tick = tick_auto ? (cyc[1:0] == 2'd0) : tick_man;

    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    genius_game_ctrl dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start1), .in_valid(in_valid1),
        .in_color(in_color1), .led(led1), .score(score1), .awaiting(awaiting1),
        .busy(busy1), .win(win1), .lose(lose1)
    );

    genius_game_ctrl #(.MAX_LEN(2)) dut2 (
        .clk(clk), .rst(rst), .tick(tick), .start(start2), .in_valid(in_valid2),
        .in_color(in_color2), .led(led2), .score(score2), .awaiting(awaiting2),
        .busy(busy2), .win(win2), .lose(lose2)
    );

    logic [3:0] led_s;
    logic       awaiting_s;
    assign led_s      = sel ? led2 : led1;
    assign awaiting_s = sel ? awaiting2 : awaiting1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] dec(input logic [3:0] l);
        case (l)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [1:0] c);
        if (sel) begin in_valid2 = v; in_color2 = c; end
        else     begin in_valid1 = v; in_color1 = c; end
    endtask

    task automatic press(input logic [1:0] c);
        set_in(1'b1, c);
        step(); step(); step();
        set_in(1'b0, c);
        step();
    endtask

    task automatic observe(input int n);
        int b;
        for (int k = 0; k < n; k++) begin
            b = 0;
            while (led_s == 4'd0 && b < 60) begin step(); b++; end
            chk("obs_onehot", $countones(led_s), 1);
            seen[k] = dec(led_s);
            b = 0;
            while (led_s != 4'd0 && b < 60) begin step(); b++; end
            chk("obs_dark", led_s, 0);
        end
    endtask

    task automatic wait_await();
        int b;
        b = 0;
        while (!awaiting_s && b < 60) begin step(); b++; end
        chk("await", awaiting_s, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, m, b;
        logic [1:0] exp0, w;
        rst = 1'b0; tick_auto = 1'b1; tick_man = 1'b0;
        start1 = 1'b0; in_valid1 = 1'b0; in_color1 = 2'd0;
        start2 = 1'b0; in_valid2 = 1'b0; in_color2 = 2'd0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start1 = 1'($urandom_range(1)); in_valid1 = 1'($urandom_range(1));
            in_color1 = 2'($urandom_range(3));
            step();
        end
        chk("rst_led", led1, 0);
        chk("rst_score", score1, 0);
        chk("rst_flags", {busy1, awaiting1, win1, lose1}, 0);
        start1 = 1'b0; in_valid1 = 1'b0; in_color1 = 2'd0;
        rst = 1'b1;
        step(); step(); step();
        chk("idle_hold", {busy1, awaiting1, win1, lose1, led1}, 0);

        // playback timing, start aligned to the tick phase
        b = 0;
        while (cyc[1:0] != 2'd3 && b < 8) begin step(); b++; end
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        exp0 = m_lfsr[1:0];
        chk("append_busy", busy1, 1);
        step();
        chk("first_color", led1, 4'b0001 << exp0);
        n = 0;
        while (led1 != 4'd0 && n < 40) begin step(); n++; end
        chk("show_len", n, 16);
        m = 0;
        while (led1 == 4'd0 && !awaiting1 && m < 40) begin step(); m++; end
        chk("gap_len", m, 8);
        chk("wait_flags", {awaiting1, busy1}, 2'b11);
        hist[0] = exp0;

        // correct play over three rounds, then round 4 playback
        press(hist[0]);
        chk("score_r1", score1, 1);
        for (int r = 2; r <= 4; r++) begin
            observe(r);
            for (int k = 0; k < r - 1; k++) chk("repeat", seen[k], hist[k]);
            hist[r-1] = seen[r-1];
            wait_await();
            if (r < 4) begin
                for (int k = 0; k < r; k++) press(hist[k]);
                chk("score_rn", score1, r);
            end
        end

        // timeout on the 40th tick
        tick_auto = 1'b0;
        for (int i = 0; i < 39; i++) begin
            tick_man = 1'b1; step(); tick_man = 1'b0; step();
        end
        chk("to_39", {awaiting1, lose1}, 2'b10);
        tick_man = 1'b1; step(); tick_man = 1'b0;
        chk("to_lose", {lose1, busy1, awaiting1, led1}, 7'b1000000);
        chk("to_score", score1, 3);

        // game 2: press coincident with 40th tick goes to CHECK
        tick_auto = 1'b1;
        start1 = 1'b1; step(); start1 = 1'b0;
        chk("g2_start", {score1, busy1}, 6'b000001);
        observe(1);
        wait_await();
        press(seen[0]);
        chk("g2_score1", score1, 1);
        observe(2);
        wait_await();
        tick_auto = 1'b0;
        for (int i = 0; i < 39; i++) begin
            tick_man = 1'b1; step(); tick_man = 1'b0; step();
        end
        in_color1 = seen[0]; in_valid1 = 1'b1; tick_man = 1'b1;
        step();
        tick_man = 1'b0;
        chk("coinc_check", {awaiting1, lose1, busy1}, 3'b001);
        step();
        chk("coinc_back", {awaiting1, lose1}, 2'b10);
        in_valid1 = 1'b0; step();
        w = seen[1] + 2'd1;
        in_color1 = w; in_valid1 = 1'b1;
        step(); step();
        chk("g2_lose", {lose1, score1}, 6'b100001);
        in_valid1 = 1'b0;

        // game 3: wrong color in round 2 at idx 0
        tick_auto = 1'b1;
        start1 = 1'b1; step(); start1 = 1'b0;
        observe(1);
        wait_await();
        press(seen[0]);
        chk("g3_score1", score1, 1);
        observe(2);
        wait_await();
        w = seen[0] + 2'd1;
        in_color1 = w; in_valid1 = 1'b1;
        step();
        chk("wrong_check", {lose1, busy1}, 2'b01);
        step();
        chk("wrong_lose", {lose1, led1, score1}, 10'b1_0000_00001);
        in_valid1 = 1'b0; step();
        in_valid1 = 1'b1; step(); step();
        in_valid1 = 1'b0;
        chk("lose_stuck", {lose1, busy1, score1}, 7'b1000001);
        start1 = 1'b1; step(); start1 = 1'b0;
        chk("restart", {score1, busy1, lose1}, 7'b0000010);

        // MAX_LEN=2 instance: held level and full win
        sel = 1'b1;
        start2 = 1'b1; step(); start2 = 1'b0;
        exp0 = m_lfsr[1:0];
        observe(1);
        chk("d2_color", seen[0], exp0);
        wait_await();
        press(seen[0]);
        chk("d2_score1", {score2, win2}, 6'b000010);
        observe(2);
        in_color2 = seen[0]; in_valid2 = 1'b1;
        wait_await();
        step(); step(); step();
        chk("held_level", awaiting2, 1);
        in_valid2 = 1'b0; step();
        in_valid2 = 1'b1; step();
        chk("rise_check", {awaiting2, busy2}, 2'b01);
        step();
        chk("rise_back", awaiting2, 1);
        in_valid2 = 1'b0; step();
        in_color2 = seen[1]; in_valid2 = 1'b1;
        step(); step();
        chk("win_flags", {win2, busy2, lose2}, 3'b100);
        chk("win_led", led2, 4'b1111);
        chk("win_score", score2, 2);
        in_valid2 = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
